// File: rtl/obsidian_fetch_ctrl_pkg.sv
// Shared definitions for the Obsidian instruction-fetch controller:
// default widths and the fetch FSM state encoding.
package obsidian_fetch_ctrl_pkg;

  localparam int OBS_ADDR_W  = 32;
  localparam int OBS_INSTR_W = 32;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/obsidian_fetch_ctrl_if.sv
// Instruction-memory request/response bundle: one word request at a time,
// accepted on req & ready, answered later by a single rvalid beat.
interface obsidian_fetch_ctrl_if
  import obsidian_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = OBS_ADDR_W,
  parameter int INSTR_W = OBS_INSTR_W
);

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ready;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);

endinterface

// File: rtl/obsidian_fetch_skid.sv
// One-entry {pc, instr} holding register that catches a fetch response
// arriving while decode is stalled.
module obsidian_fetch_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  // Draining and flushing both empty the entry; either beats a same-cycle load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (clear || unload) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= din;
    end
  end

  assign valid = valid_reg;
  assign dout  = data_reg;

endmodule

// File: rtl/obsidian_fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one imem request in flight at most,
// and fills the IF/ID register, with branch redirects flushing the path.
module obsidian_fetch_ctrl
  import obsidian_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = OBS_ADDR_W,
  parameter int                INSTR_W  = OBS_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  obsidian_fetch_ctrl_if.master     imem,
  input  logic                      stall,
  input  logic                      br_taken,
  input  logic [ADDR_W-1:0]         br_target,
  output logic                      if_id_valid,
  output logic [ADDR_W+INSTR_W-1:0] IF_ID
);

  localparam int W = ADDR_W + INSTR_W;

  fetch_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              if_id_valid_reg, if_id_valid_next;
  logic [W-1:0]      if_id_reg, if_id_next;

  logic              free;
  logic              consume;
  logic              req;
  logic              skid_load, skid_unload, skid_clear;
  logic              skid_valid;
  logic [W-1:0]      skid_data;

  obsidian_fetch_skid #(.W(W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    ({pc_reg, imem.rdata}),
    .valid  (skid_valid),
    .dout   (skid_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      if_id_valid_reg <= 1'b0;
      if_id_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      if_id_valid_reg <= if_id_valid_next;
      if_id_reg       <= if_id_next;
    end
  end

  always_comb begin
    free    = !if_id_valid_reg || !stall;
    consume = if_id_valid_reg && !stall;
    req     = (state_reg == S_FETCH) && free && !br_taken && !rst;

    state_next       = state_reg;
    pc_next          = pc_reg;
    if_id_valid_next = if_id_valid_reg && !consume;
    if_id_next       = if_id_reg;
    skid_load        = 1'b0;
    skid_unload      = 1'b0;
    skid_clear       = 1'b0;

    // rvalid outside WAIT/DISCARD is a protocol error and is simply ignored.
    case (state_reg)
      S_FETCH: begin
        if (req && imem.ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          pc_next = pc_reg + ADDR_W'(1);
          if (free) begin
            if_id_next       = {pc_reg, imem.rdata};
            if_id_valid_next = 1'b1;
            state_next       = S_FETCH;
          end else begin
            skid_load  = 1'b1;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall && skid_valid) begin
          if_id_next       = skid_data;
          if_id_valid_next = 1'b1;
          skid_unload      = 1'b1;
          state_next       = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (imem.rvalid) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // A redirect overrides everything above, including stall. A request
    // still in flight must have its response swallowed in DISCARD.
    if (br_taken) begin
      pc_next          = br_target;
      if_id_valid_next = 1'b0;
      if_id_next       = if_id_reg;
      skid_load        = 1'b0;
      skid_unload      = 1'b0;
      skid_clear       = 1'b1;
      if ((state_reg == S_DISCARD) || (state_reg == S_WAIT && !imem.rvalid))
        state_next = S_DISCARD;
      else
        state_next = S_FETCH;
    end
  end

  assign imem.req    = req;
  assign imem.addr   = pc_reg;
  assign if_id_valid = if_id_valid_reg;
  assign IF_ID       = if_id_reg;

endmodule

// File: tb/tb_obsidian_fetch_ctrl.sv
// Bench for obsidian_fetch_ctrl: directed vector table, hand-written async
// reset sequence, and randomized traffic against a transaction-level model.
module tb_obsidian_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_id_valid;
  logic [63:0] IF_ID;

  obsidian_fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) imem_if ();

  obsidian_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_if),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .if_id_valid (if_id_valid),
    .IF_ID       (IF_ID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_ifid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] t, logic rdy,
                              logic rv, logic [31:0] rd, logic er, logic [31:0] ea,
                              logic ev, logic [63:0] ei);
    vec_t v;
    v.rst_first = r;  v.stall = s;   v.br = b;        v.tgt = t;
    v.ready = rdy;    v.rvalid = rv; v.rdata = rd;
    v.exp_req = er;   v.exp_addr = ea; v.exp_valid = ev; v.exp_ifid = ei;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    stall          = 1'b0;
    br_taken       = 1'b0;
    br_target      = '0;
    imem_if.ready  = 1'b0;
    imem_if.rvalid = 1'b0;
    imem_if.rdata  = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t        v;
  logic        s_req;
  logic [31:0] s_addr;
  logic [63:0] ifid_same;
  logic [31:0] exp_pc;
  logic        outstanding;
  int          cnt;
  logic [31:0] pend_addr;
  logic        prev_br, prev_hold;
  logic [63:0] prev_ifid;
  int          delivered;

  initial begin
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset req gated", imem_if.req, 0);
    check("reset addr", imem_if.addr, 0);
    check("reset valid", if_id_valid, 0);
    check("reset if_id", IF_ID, 0);

    // Linear fetch, zero-wait memory
    vecs.push_back(mk(1,0,0,0,1,0,0,            1,32'h0,0,64'h0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hFFFFFFFF, 0,32'h0,1,64'h00000000_FFFFFFFF));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h1,0,64'h00000000_FFFFFFFF));
    vecs.push_back(mk(0,0,0,0,0,1,32'h00000000, 0,32'h1,1,64'h00000001_00000000));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h2,0,64'h00000001_00000000));
    vecs.push_back(mk(0,0,0,0,0,1,32'hAAAAAAAA, 0,32'h2,1,64'h00000002_AAAAAAAA));
    // Stall: IF_ID holds, no request until released
    vecs.push_back(mk(1,0,0,0,1,0,0,            1,32'h0,0,64'h0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h11110000, 0,32'h0,1,64'h00000000_11110000));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,1,0,0,1,0,0,          0,32'h1,1,64'h00000000_11110000));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h1,0,64'h00000000_11110000));
    vecs.push_back(mk(0,1,0,0,0,1,32'h22220001, 0,32'h1,1,64'h00000001_22220001));
    vecs.push_back(mk(0,1,0,0,1,0,0,            0,32'h2,1,64'h00000001_22220001));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h2,0,64'h00000001_22220001));
    vecs.push_back(mk(0,0,0,0,0,1,32'h33330002, 0,32'h2,1,64'h00000002_33330002));
    // Branch in WAIT, second branch while discarding, stale data dropped
    vecs.push_back(mk(1,0,1,32'h5,1,0,0,        0,32'h0,0,64'h0));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h5,0,64'h0));
    vecs.push_back(mk(0,0,1,32'h40,1,0,0,       0,32'h5,0,64'h0));
    vecs.push_back(mk(0,0,1,32'h50,1,0,0,       0,32'h40,0,64'h0));
    vecs.push_back(mk(0,0,0,0,1,1,32'hDEAD0005, 0,32'h50,0,64'h0));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h50,0,64'h0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h44440050, 0,32'h50,1,64'h00000050_44440050));
    // Branch coincident with rvalid, without and with stall
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h51,0,64'h00000050_44440050));
    vecs.push_back(mk(0,0,1,32'h10,0,1,32'hBAD00051, 0,32'h51,0,64'h00000050_44440050));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h10,0,64'h00000050_44440050));
    vecs.push_back(mk(0,1,1,32'h20,0,1,32'hBAD00010, 0,32'h10,0,64'h00000050_44440050));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h20,0,64'h00000050_44440050));
    vecs.push_back(mk(0,0,0,0,0,1,32'h55550020, 0,32'h20,1,64'h00000020_55550020));
    // PC wrap
    vecs.push_back(mk(0,0,1,32'hFFFFFFFF,1,0,0, 0,32'h21,0,64'h00000020_55550020));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'hFFFFFFFF,0,64'h00000020_55550020));
    vecs.push_back(mk(0,0,0,0,0,1,32'h66666666, 0,32'hFFFFFFFF,1,64'hFFFFFFFF_66666666));
    vecs.push_back(mk(0,0,0,0,1,0,0,            1,32'h0,0,64'hFFFFFFFF_66666666));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst_first) do_reset();
      stall          = v.stall;
      br_taken       = v.br;
      br_target      = v.tgt;
      imem_if.ready  = v.ready;
      imem_if.rvalid = v.rvalid;
      imem_if.rdata  = v.rdata;
      @(negedge clk);
      s_req  = imem_if.req;
      s_addr = imem_if.addr;
      check($sformatf("vec%0d req", i), s_req, v.exp_req);
      check($sformatf("vec%0d addr", i), s_addr, v.exp_addr);
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", i), if_id_valid, v.exp_valid);
      check($sformatf("vec%0d if_id", i), IF_ID, v.exp_ifid);
      $display("vec %0d: req=%b addr=%h valid=%b if_id=%h", i, s_req, s_addr, if_id_valid, IF_ID);
    end

    // Async reset while a request is in flight
    do_reset();
    imem_if.ready = 1'b1;
    @(posedge clk); #1;
    imem_if.ready  = 1'b0;
    imem_if.rvalid = 1'b1;
    imem_if.rdata  = 32'h77777777;
    @(posedge clk); #1;
    imem_if.rvalid = 1'b0;
    imem_if.ready  = 1'b1;
    @(posedge clk); #1;
    imem_if.ready = 1'b0;
    ifid_same = IF_ID;
    check("pre-reset if_id", ifid_same, 64'h00000000_77777777);
    #2 rst = 1'b1;
    #1;
    check("async rst req", imem_if.req, 0);
    check("async rst addr", imem_if.addr, 0);
    check("async rst valid", if_id_valid, 0);
    check("async rst if_id", IF_ID, 0);
    $display("async reset: req=%b addr=%h valid=%b if_id=%h", imem_if.req, imem_if.addr, if_id_valid, IF_ID);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset req", imem_if.req, 1);
    check("post-reset addr", imem_if.addr, 0);
    @(posedge clk); #1;

    // Randomized traffic against a delivery-order model
    do_reset();
    exp_pc      = 32'h0;
    outstanding = 1'b0;
    cnt         = 0;
    pend_addr   = '0;
    prev_br     = 1'b0;
    prev_hold   = 1'b0;
    prev_ifid   = '0;
    delivered   = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      stall          = ($urandom_range(0, 99) < 35);
      br_taken       = ($urandom_range(0, 99) < 6);
      br_target      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 63));
      imem_if.ready  = ($urandom_range(0, 99) < 70);
      imem_if.rvalid = 1'b0;
      imem_if.rdata  = $urandom;
      if (outstanding) begin
        cnt--;
        if (cnt == 0) begin
          imem_if.rvalid = 1'b1;
          imem_if.rdata  = mem_word(pend_addr);
          outstanding    = 1'b0;
        end
      end
      @(negedge clk);
      if (prev_br) check("valid after branch", if_id_valid, 0);
      if (prev_hold) begin
        check("stalled valid held", if_id_valid, 1);
        check("stalled if_id held", IF_ID, prev_ifid);
      end
      if (imem_if.req) begin
        check("req while stalled", if_id_valid && stall, 0);
        check("req while outstanding", outstanding || imem_if.rvalid, 0);
      end
      if (if_id_valid && !stall && !br_taken) begin
        check("delivered pc", IF_ID[63:32], exp_pc);
        check("delivered instr", IF_ID[31:0], mem_word(exp_pc));
        $display("rnd deliver: pc=%h instr=%h", IF_ID[63:32], IF_ID[31:0]);
        exp_pc = exp_pc + 32'h1;
        delivered++;
      end
      if (br_taken) exp_pc = br_target;
      if (imem_if.req && imem_if.ready) begin
        outstanding = 1'b1;
        cnt         = $urandom_range(1, 3);
        pend_addr   = imem_if.addr;
      end
      prev_br   = br_taken;
      prev_hold = if_id_valid && stall && !br_taken;
      prev_ifid = IF_ID;
      @(posedge clk); #1;
    end
    check("random progress", delivered >= 60, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
